// File: rtl/tri_perspective_proj.sv
// Per-triangle camera-relative yaw rotation and perspective divide with near-plane culling.
// One restoring divider is shared across the six screen coordinates and runs one bit per cycle.
module tri_perspective_proj #(
   parameter int COORD_W     = 6,
   parameter int CAM_W       = 7,
   parameter int TRIG_W      = 8,
   parameter int COLOR_W     = 10,
   parameter int OUT_W       = 8,
   parameter int FOCAL_SHIFT = 4,
   parameter int NEAR_Z      = 1,
   parameter int CNT_W       = 16,
   localparam int D_W        = ((COORD_W > CAM_W) ? COORD_W : CAM_W) + 1,
   localparam int R_W        = D_W + 1,
   localparam int DIV_STEPS  = R_W + FOCAL_SHIFT,
   localparam int TRI_W      = 9*COORD_W + COLOR_W,
   localparam int OT_W       = 6*OUT_W + R_W + COLOR_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [TRI_W-1:0]   in_tri,
   input  logic [CAM_W-1:0]   cam_x,
   input  logic [CAM_W-1:0]   cam_y,
   input  logic [CAM_W-1:0]   cam_z,
   input  logic [TRIG_W-1:0]  sin_val,
   input  logic [TRIG_W-1:0]  cos_val,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OT_W-1:0]    out_tri,
   output logic [CNT_W-1:0]   cull_count
);
   localparam int P_W  = D_W + TRIG_W + 1;
   localparam int ST_W = $clog2(DIV_STEPS);
   localparam int MAXO = 2**(OUT_W-1) - 1;
   localparam logic signed [R_W-1:0] NEAR_R = R_W'(NEAR_Z);

   typedef enum logic [1:0] {IDLE, XFORM, DIV, OUT} state_t;

   state_t                   state_q, state_d;
   logic                     rdy_q;
   logic [TRI_W-1:0]         tri_q, tri_d;
   logic signed [CAM_W-1:0]  cam_q [3], cam_d [3];
   logic signed [TRIG_W-1:0] sin_q, sin_d, cos_q, cos_d;
   logic signed [R_W-1:0]    xr_q [3], xr_d [3], yr_q [3], yr_d [3], zr_q [3], zr_d [3];
   logic                     load_q, load_d;
   logic [2:0]               idx_q, idx_d;
   logic [ST_W-1:0]          step_q, step_d;
   logic [R_W-1:0]           rem_q, rem_d;
   logic [DIV_STEPS-1:0]     dq_q, dq_d;
   logic [OUT_W-1:0]         s_q [6], s_d [6];
   logic [OT_W-1:0]          ot_q, ot_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;

   logic signed [COORD_W-1:0] vx [3], vy [3], vz [3];
   logic signed [D_W-1:0]     dx [3], dy [3], dz [3];
   logic signed [P_W-1:0]     ex, ez, cs, sn, rx, rz;
   logic signed [R_W-1:0]     xr_n [3], yr_n [3], zr_n [3];

   always_comb begin
      ex = '0; ez = '0; rx = '0; rz = '0;
      cs = P_W'(cos_q);
      sn = P_W'(sin_q);
      for (int unsigned i = 0; i < 3; i++) begin
         vx[i] = tri_q[COLOR_W + (8-3*i)*COORD_W +: COORD_W];
         vy[i] = tri_q[COLOR_W + (7-3*i)*COORD_W +: COORD_W];
         vz[i] = tri_q[COLOR_W + (6-3*i)*COORD_W +: COORD_W];
         dx[i] = D_W'(vx[i]) - D_W'(cam_q[0]);
         dy[i] = D_W'(vy[i]) - D_W'(cam_q[1]);
         dz[i] = D_W'(vz[i]) - D_W'(cam_q[2]);
         ex = P_W'(dx[i]);
         ez = P_W'(dz[i]);
         rx = ex*cs + ez*sn;
         rz = ez*cs - ex*sn;
         xr_n[i] = R_W'(rx >>> (TRIG_W-2));
         zr_n[i] = R_W'(rz >>> (TRIG_W-2));
         yr_n[i] = R_W'(dy[i]);
      end
   end

   logic signed [R_W-1:0] cval [8];
   logic signed [R_W-1:0] sel, zmax;
   logic [R_W-1:0]        mag_n, zdiv;
   logic [DIV_STEPS-1:0]  num_n, dq_s;
   logic [2:0]            nidx;
   logic [R_W:0]          sh, diff;
   logic [R_W-1:0]        rem_s;
   logic                  qb, cull, neg;
   logic [OUT_W-1:0]      qc, res;

   // Operand for the next quotient is fetched while the current one finishes, so quotients run back to back.
   always_comb begin
      for (int unsigned k = 0; k < 8; k++) cval[k] = '0;
      for (int unsigned k = 0; k < 3; k++) begin
         cval[2*k]   = xr_q[k];
         cval[2*k+1] = yr_q[k];
      end
      nidx  = load_q ? 3'd0 : idx_q + 3'd1;
      sel   = cval[nidx];
      mag_n = sel[R_W-1] ? -sel : sel;
      num_n = {mag_n, {FOCAL_SHIFT{1'b0}}};
      zdiv  = zr_q[idx_q[2:1]];
      sh    = {rem_q, dq_q[DIV_STEPS-1]};
      diff  = sh - {1'b0, zdiv};
      qb    = ~diff[R_W];
      rem_s = qb ? diff[R_W-1:0] : sh[R_W-1:0];
      dq_s  = {dq_q[DIV_STEPS-2:0], qb};
      qc    = (dq_s > DIV_STEPS'(MAXO)) ? OUT_W'(MAXO) : dq_s[OUT_W-1:0];
      neg   = cval[idx_q][R_W-1];
      res   = neg ? -qc : qc;
      cull  = 1'b0;
      zmax  = zr_q[0];
      for (int unsigned i = 0; i < 3; i++) begin
         if (zr_q[i] < NEAR_R) cull = 1'b1;
         if (zr_q[i] > zmax)   zmax = zr_q[i];
      end
   end

   always_comb begin
      state_d = state_q;
      tri_d   = tri_q;
      cam_d   = cam_q;
      sin_d   = sin_q;
      cos_d   = cos_q;
      xr_d    = xr_q;
      yr_d    = yr_q;
      zr_d    = zr_q;
      load_d  = load_q;
      idx_d   = idx_q;
      step_d  = step_q;
      rem_d   = rem_q;
      dq_d    = dq_q;
      s_d     = s_q;
      ot_d    = ot_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid && rdy_q) begin
               tri_d    = in_tri;
               cam_d[0] = cam_x;
               cam_d[1] = cam_y;
               cam_d[2] = cam_z;
               sin_d    = sin_val;
               cos_d    = cos_val;
               state_d  = XFORM;
            end
         end
         XFORM: begin
            xr_d    = xr_n;
            yr_d    = yr_n;
            zr_d    = zr_n;
            load_d  = 1'b1;
            state_d = DIV;
         end
         DIV: begin
            if (load_q) begin
               if (cull) begin
                  state_d = IDLE;
                  if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  load_d = 1'b0;
                  idx_d  = '0;
                  step_d = '0;
                  rem_d  = '0;
                  dq_d   = num_n;
               end
            end else begin
               rem_d  = rem_s;
               dq_d   = dq_s;
               step_d = step_q + ST_W'(1);
               if (step_q == ST_W'(DIV_STEPS-1)) begin
                  s_d[idx_q] = res;
                  step_d     = '0;
                  rem_d      = '0;
                  dq_d       = num_n;
                  idx_d      = idx_q + 3'd1;
                  if (idx_q == 3'd5) begin
                     ot_d    = {s_q[0], s_q[1], s_q[2], s_q[3], s_q[4], res, zmax, tri_q[COLOR_W-1:0]};
                     state_d = OUT;
                  end
               end
            end
         end
         OUT: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready   = rdy_q && (state_q == IDLE);
   assign out_valid  = (state_q == OUT);
   assign out_tri    = ot_q;
   assign cull_count = cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         rdy_q   <= 1'b0;
         tri_q   <= '0;
         sin_q   <= '0;
         cos_q   <= '0;
         load_q  <= 1'b0;
         idx_q   <= '0;
         step_q  <= '0;
         rem_q   <= '0;
         dq_q    <= '0;
         ot_q    <= '0;
         cnt_q   <= '0;
         for (int unsigned i = 0; i < 3; i++) begin
            cam_q[i] <= '0;
            xr_q[i]  <= '0;
            yr_q[i]  <= '0;
            zr_q[i]  <= '0;
         end
         for (int unsigned i = 0; i < 6; i++) s_q[i] <= '0;
      end else begin
         state_q <= state_d;
         rdy_q   <= 1'b1;
         tri_q   <= tri_d;
         cam_q   <= cam_d;
         sin_q   <= sin_d;
         cos_q   <= cos_d;
         xr_q    <= xr_d;
         yr_q    <= yr_d;
         zr_q    <= zr_d;
         load_q  <= load_d;
         idx_q   <= idx_d;
         step_q  <= step_d;
         rem_q   <= rem_d;
         dq_q    <= dq_d;
         s_q     <= s_d;
         ot_q    <= ot_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_tri_perspective_proj.sv
// Directed and randomized checks of tri_perspective_proj against an integer-arithmetic projection model.
module tb_tri_perspective_proj;
   localparam int TRI_W = 64;
   localparam int OT_W  = 67;

   logic              clk = 1'b0;
   logic              rst, in_valid, in_ready, out_valid, out_ready;
   logic [TRI_W-1:0]  in_tri;
   logic [6:0]        cam_x, cam_y, cam_z;
   logic [7:0]        sin_val, cos_val;
   logic [OT_W-1:0]   out_tri;
   logic [15:0]       cull_count;

   int vectors     = 0;
   int miscompares = 0;
   int exp_cull    = 0;

   always #5 clk = ~clk;

   tri_perspective_proj #(
      .COORD_W(6), .CAM_W(7), .TRIG_W(8), .COLOR_W(10), .OUT_W(8),
      .FOCAL_SHIFT(4), .NEAR_Z(1), .CNT_W(16)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_tri(in_tri),
      .cam_x(cam_x), .cam_y(cam_y), .cam_z(cam_z), .sin_val(sin_val), .cos_val(cos_val),
      .out_valid(out_valid), .out_ready(out_ready), .out_tri(out_tri), .cull_count(cull_count)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [TRI_W-1:0] mk(input int c[9], input int color);
      logic [TRI_W-1:0] t;
      t = '0;
      for (int k = 0; k < 9; k++) t[10 + (8-k)*6 +: 6] = 6'(c[k]);
      t[9:0] = 10'(color);
      return t;
   endfunction

   function automatic logic [OT_W-1:0] pack(input int s[6], input int dep, input int color);
      return {8'(s[0]), 8'(s[1]), 8'(s[2]), 8'(s[3]), 8'(s[4]), 8'(s[5]), 9'(dep), 10'(color)};
   endfunction

   function automatic int proj(input int c, input int z);
      int q;
      q = ((c < 0 ? -c : c) * 16) / z;
      if (q > 127) q = 127;
      return (c < 0) ? -q : q;
   endfunction

   // Reference: camera-relative, rotate, floor-scale, then focal divide with symmetric clamp.
   function automatic logic [OT_W-1:0] model(input logic [TRI_W-1:0] t, input int cx, input int cy,
                                             input int cz, input int sn, input int cs, output bit cull);
      int v[9]; int xr[3]; int yr[3]; int zr[3]; int s[6]; int dep;
      logic signed [5:0] tmp;
      for (int k = 0; k < 9; k++) begin
         tmp  = t[10 + (8-k)*6 +: 6];
         v[k] = tmp;
      end
      cull = 1'b0;
      dep  = 0;
      for (int i = 0; i < 3; i++) begin
         int dx, dy, dz;
         dx = v[3*i] - cx; dy = v[3*i+1] - cy; dz = v[3*i+2] - cz;
         xr[i] = (dx*cs + dz*sn) >>> 6;
         zr[i] = (dz*cs - dx*sn) >>> 6;
         yr[i] = dy;
         if (zr[i] < 1) cull = 1'b1;
         if (zr[i] > dep) dep = zr[i];
      end
      if (cull) return '0;
      for (int i = 0; i < 3; i++) begin
         s[2*i]   = proj(xr[i], zr[i]);
         s[2*i+1] = proj(yr[i], zr[i]);
      end
      return pack(s, dep, int'(t[9:0]));
   endfunction

   task automatic drive(input logic [TRI_W-1:0] t, input int cx, input int cy, input int cz,
                        input int sn, input int cs);
      in_tri = t; cam_x = 7'(cx); cam_y = 7'(cy); cam_z = 7'(cz);
      sin_val = 8'(sn); cos_val = 8'(cs); in_valid = 1'b1;
   endtask

   task automatic accept(input string tag);
      int n = 0;
      while (!in_ready && n < 300) begin
         @(posedge clk); #1; n++;
      end
      check({tag, "_ready_wait"}, 128'(n < 300), 128'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_tri   = {$urandom, $urandom};
      cam_x = 7'($urandom); cam_y = 7'($urandom); cam_z = 7'($urandom);
      sin_val = 8'($urandom); cos_val = 8'($urandom);
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 300) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   task automatic run_tri(input string tag, input logic [TRI_W-1:0] t, input int cx, input int cy,
                          input int cz, input int sn, input int cs, input bit use_lit,
                          input logic [OT_W-1:0] lit, input bit lit_cull);
      logic [OT_W-1:0] exp;
      bit cull;
      int lat;
      exp = model(t, cx, cy, cz, sn, cs, cull);
      if (use_lit) begin
         exp  = lit;
         cull = lit_cull;
      end
      drive(t, cx, cy, cz, sn, cs);
      accept(tag);
      if (cull) begin
         exp_cull++;
         @(posedge clk); #1;
         check({tag, "_cull_busy"}, 128'(in_ready), 128'(0));
         @(posedge clk); #1;
         check({tag, "_cull_ready"}, 128'(in_ready), 128'(1));
         check({tag, "_cull_noout"}, 128'(out_valid), 128'(0));
         check({tag, "_cull_count"}, 128'(cull_count), 128'(exp_cull));
      end else begin
         wait_out(lat);
         check({tag, "_latency"}, 128'(lat), 128'(80));
         check({tag, "_tri"}, 128'(out_tri), 128'(exp));
         @(posedge clk); #1;
         check({tag, "_drained"}, 128'(out_valid), 128'(0));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cs_t[9] = '{64, 0, -64, 0, 45, 45, -45, 55, 32};
      int sn_t[9] = '{0, 64, 0, -64, 45, -45, 45, 32, -55};
      int c[9];
      int lat, a;
      logic [TRI_W-1:0] ta, tb;
      logic [OT_W-1:0]  ea, eb, snap;
      bit cl;

      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_tri = '0;
      cam_x = '0; cam_y = '0; cam_z = '0; sin_val = '0; cos_val = '0;
      #3;
      check("rst_in_ready", 128'(in_ready), 128'(0));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_out_tri", 128'(out_tri), 128'(0));
      check("rst_cull", 128'(cull_count), 128'(0));
      #20;
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      check("rst_release_ready", 128'(in_ready), 128'(1));

      run_tri("basic", mk('{4, 2, 8, -4, 2, 8, 0, -6, 16}, 'h3FF), 0, 0, 0, 0, 64,
              1'b1, pack('{8, 4, -8, 4, 0, -6}, 16, 'h3FF), 1'b0);
      run_tri("near_cull", mk('{4, 2, 8, -4, 2, 8, 0, -6, 0}, 'h3FF), 0, 0, 0, 0, 64,
              1'b1, '0, 1'b1);
      run_tri("yaw90", mk('{-10, 0, 5, -10, 0, 5, -10, 0, 5}, 'h0A5), 0, 0, 0, 64, 0,
              1'b1, pack('{8, 0, 8, 0, 8, 0}, 10, 'h0A5), 1'b0);
      run_tri("sat_pos", mk('{31, 0, 1, 31, 0, 1, 31, 0, 1}, 'h155), 0, 0, 0, 0, 64,
              1'b1, pack('{127, 0, 127, 0, 127, 0}, 1, 'h155), 1'b0);
      run_tri("sat_neg", mk('{-32, 0, 1, -32, 0, 1, -32, 0, 1}, 'h2AA), 0, 0, 0, 0, 64,
              1'b1, pack('{-127, 0, -127, 0, -127, 0}, 1, 'h2AA), 1'b0);

      for (int n = 0; n < 20; n++) begin
         for (int k = 0; k < 9; k++) c[k] = int'($urandom_range(0, 63)) - 32;
         a = int'($urandom_range(0, 8));
         run_tri("rand", mk(c, int'($urandom_range(0, 1023))),
                 int'($urandom_range(0, 40)) - 20, int'($urandom_range(0, 40)) - 20,
                 int'($urandom_range(0, 40)) - 60, sn_t[a], cs_t[a], 1'b0, '0, 1'b0);
      end

      // Backpressure: hold the result, queue a second triangle behind it.
      ta = mk('{5, -3, 9, -7, 4, 12, 2, 6, 20}, 'h123);
      tb = mk('{-9, 8, 14, 3, -2, 7, 11, 1, 25}, 'h321);
      ea = model(ta, 1, -2, -5, 45, 45, cl);
      eb = model(tb, -3, 0, -4, 32, 55, cl);
      out_ready = 1'b0;
      drive(ta, 1, -2, -5, 45, 45);
      accept("bp_a");
      wait_out(lat);
      check("bp_a_latency", 128'(lat), 128'(80));
      check("bp_a_tri", 128'(out_tri), 128'(ea));
      snap = out_tri;
      drive(tb, -3, 0, -4, 32, 55);
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         check("bp_hold_tri", 128'(out_tri), 128'(snap));
         check("bp_hold_valid", 128'(out_valid), 128'(1));
         check("bp_hold_inready", 128'(in_ready), 128'(0));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_handshake_valid", 128'(out_valid), 128'(0));
      check("bp_handshake_idle", 128'(in_ready), 128'(1));
      @(posedge clk); #1;
      check("bp_b_accepted", 128'(in_ready), 128'(0));
      in_valid = 1'b0;
      in_tri = {$urandom, $urandom}; cos_val = 8'($urandom);
      wait_out(lat);
      check("bp_b_latency", 128'(lat), 128'(80));
      check("bp_b_tri", 128'(out_tri), 128'(eb));
      @(posedge clk); #1;

      // Asynchronous reset in the middle of the divide.
      drive(ta, 1, -2, -5, 45, 45);
      accept("mid_rst");
      repeat (30) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("mid_rst_out_valid", 128'(out_valid), 128'(0));
      check("mid_rst_out_tri", 128'(out_tri), 128'(0));
      check("mid_rst_in_ready", 128'(in_ready), 128'(0));
      check("mid_rst_cull", 128'(cull_count), 128'(0));
      exp_cull = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_release_ready", 128'(in_ready), 128'(1));
      run_tri("after_rst", tb, -3, 0, -4, 32, 55, 1'b0, '0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
